// File: rtl/expr_pkg.sv
// Shared constants, state encoding and character classes for the expression
// frame controller.
package expr_pkg;

  localparam logic [7:0] CH_ZERO = 8'd48;
  localparam logic [7:0] CH_NINE = 8'd57;
  localparam logic [7:0] CH_PLUS = 8'd43;
  localparam logic [7:0] CH_MUL  = 8'd42;
  localparam logic [7:0] CH_TERM = 8'd59;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_NUM   = 2'd1,
    S_OP    = 2'd2,
    S_ERR   = 2'd3
  } expr_state_t;

  typedef enum logic [1:0] {
    DIGIT = 2'd0,
    OP    = 2'd1,
    TERM  = 2'd2,
    OTHER = 2'd3
  } char_class_t;

  // Grammar step for non-terminator characters: digit ((+|*) digit)*
  function automatic expr_state_t next_state(input expr_state_t s, input char_class_t c);
    expr_state_t n;
    n = S_ERR;
    if (c == DIGIT && (s == S_START || s == S_OP)) n = S_NUM;
    else if (c == OP && s == S_NUM) n = S_OP;
    return n;
  endfunction

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: digit, operator, terminator or anything else.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls
);

  always_comb begin
    cls = OTHER;
    if (ch >= CH_ZERO && ch <= CH_NINE) cls = DIGIT;
    else if (ch == CH_PLUS || ch == CH_MUL) cls = OP;
    else if (ch == CH_TERM) cls = TERM;
  end

endmodule

// File: rtl/expr_frame_ctrl.sv
// Splits a ';'-terminated byte stream into frames, checks each against the
// expression grammar and emits one verdict per frame with saturating tallies.
module expr_frame_ctrl
  import expr_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_legal,
  output logic [LEN_W-1:0] res_len,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_valid/in_data must be held until accepted; res_* stay stable until
  // taken. in_ready is derived only from the res_valid register, so one
  // result is buffered and the input stalls while it is outstanding.

  expr_state_t      state;
  char_class_t      cls;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             frame_ok;

  expr_char_class u_class (
    .ch  (in_data),
    .cls (cls)
  );

  assign in_ready = ~res_valid;
  assign accept   = in_valid & in_ready;
  assign frame_ok = (state == S_NUM) && (len_q <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_START;
      len_q     <= '0;
      res_valid <= 1'b0;
      res_legal <= 1'b0;
      res_len   <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;

      // accept implies res_valid is low, so it never collides with the clear above
      if (accept) begin
        if (cls == TERM) begin
          res_valid <= 1'b1;
          res_len   <= len_q;
          res_legal <= frame_ok;
          if (frame_ok) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          end
          state <= S_START;
          len_q <= '0;
          busy  <= 1'b0;
        end else begin
          state <= next_state(state, cls);
          busy  <= 1'b1;
          if (len_q != '1) len_q <= len_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/expr_frame_ctrl.md
Name: expr_frame_ctrl

Overview:
Stream-side controller for the ASCII expression recognizer. It accepts a byte stream over a valid/ready handshake and splits it into frames terminated by ';' (8'd59). Each frame is checked against the grammar digit ((+|*) digit)*. One result per frame is emitted on a second valid/ready handshake, and saturating pass/fail counters are kept. It sits between the character source (UART/testbench driver) and any consumer of the verdicts.

Parameters:
MAX_LEN, 16, maximum legal frame length in characters, excluding ';'.
LEN_W, 5, width of the length field; MAX_LEN < 2^LEN_W - 1 is required.
CNT_W, 8, width of the pass/fail counters.

Ports:
clk  in  1  clock; all state changes on the rising edge.
clr  in  1  synchronous, active-high reset; highest priority.
in_valid  in  1  source presents in_data.
in_ready  out  1  block can accept a character.
in_data  in  8  ASCII character.
res_valid  out  1  frame verdict available.
res_ready  in  1  consumer takes the verdict.
res_legal  out  1  1 = frame matched the grammar and length ≤ MAX_LEN.
res_len  out  LEN_W  character count of the frame, excluding ';'; saturates at all-ones.
pass_cnt  out  CNT_W  number of legal frames; saturates at all-ones.
fail_cnt  out  CNT_W  number of illegal frames; saturates at all-ones.
busy  out  1  at least one non-';' character of the current frame has been accepted.

Behaviour:
- Reset (clr=1 at an edge):
  - state goes to S_START.
  - res_valid, res_legal, res_len, pass_cnt, fail_cnt, busy and the length counter all clear to 0.
  - A partial frame is discarded without producing a result. A pending result is dropped.
- Accept rule: a character is consumed when in_valid && in_ready at an edge. in_ready = ~res_valid, a registered signal with no combinational path from res_ready.
- Recognizer states:
  - S_START: expecting the first digit.
  - S_NUM: a digit was just seen.
  - S_OP: an operator was just seen.
  - S_ERR: sticky error until ';'.
- Transitions, for non-';' characters:
  - S_START or S_OP with a digit ('0'..'9', 48..57) -> S_NUM.
  - S_NUM with '+' (43) or '*' (42) -> S_OP.
  - Any other character in any state -> S_ERR. This includes a second consecutive digit, so multi-digit operands are illegal.
- Length: every accepted non-';' character increments the length counter, saturating at 2^LEN_W-1.
- Terminator (';' accepted):
  - At the same edge: res_valid<=1, res_len<=length, and res_legal<=(state==S_NUM && length ≤ MAX_LEN).
  - At the same edge: pass_cnt or fail_cnt increments (saturating), state<=S_START, length<=0, busy<=0.
  - Latency: the verdict is visible in the cycle after the ';' handshake.
- Empty frame (';' in S_START with length 0): illegal, res_len=0.
- Result hold:
  - res_valid, res_legal and res_len remain stable until a res_valid && res_ready edge, which clears res_valid.
  - in_ready rises the following cycle, so there is exactly one bubble after each consumed result.
- in_valid while in_ready=0: no state change; the source must hold its data.
- clr concurrent with a handshake: clr wins; nothing is accepted and no counters change.

Decomposition:
- Package expr_pkg holds:
  - ASCII constants: CH_ZERO=48, CH_NINE=57, CH_PLUS=43, CH_MUL=42, CH_TERM=59.
  - The 2-bit state encoding S_START/S_NUM/S_OP/S_ERR.
  - The character-class enum: DIGIT, OP, TERM, OTHER.
- Sub-module expr_char_class: a combinational classifier mapping 8-bit ASCII to the character class. The top-level holds the FSM, the length counter, the result register and the counters.

Test Plan:
1. After clr, send "1+2*3;" (49,43,50,42,51,59) with res_ready=1 -> res_valid=1 one cycle after ';' with res_legal=1 and res_len=5; then pass_cnt=1, fail_cnt=0.
2. Send "1+;", then "12;", then ";" -> three results, all with res_legal=0, with res_len=2, 2 and 0 respectively; fail_cnt=3.
3. Backpressure: hold res_ready=0 after the verdict of "7;" -> in_ready=0 and all outputs stable for 10 cycles. Raise res_ready -> res_valid falls at that edge and in_ready=1 the next cycle.
4. Length overflow (MAX_LEN=16): send "1+1+1+1+1+1+1+1+1;" (17 chars) -> res_legal=0, res_len=17, fail_cnt increments.
5. Reset mid-operation: send "1+", assert clr for 1 cycle, then send "5;" -> one result only, with res_legal=1, res_len=1, pass_cnt=1, fail_cnt=0.
6. Saturation (CNT_W=2): send 5 legal frames "3;" -> pass_cnt reads 1, 2, 3, 3, 3.
